// File: rtl/instr_seq_ctrl.sv
// Purpose  : per-instruction control sequencer feeding the register file and ALU (S0..S6 walk).
// Latency  : start edge -> S1 on the next clock; S6 (done) 6 clocks after the edge; back to S0 after 7.
// Backpress: none; start is ignored in S1..S6 and a held start only counts once (edge detected).
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   start              run request (level); only its rising edge in S0 launches an instruction
//   instr              {op, rd1, rd2, wr}; captured in S0 on the start edge
//   overflow           ALU overflow, sampled during writeback (S5)
//   pst                state code shared with the register file
//   Rd1, Rd2, Wr       register addresses from the captured instruction (0 while idle)
//   alu_op             opcode to the ALU (0 while idle)
//   Reg_Write          register file write enable, only in S5 for opcodes 1..8
//   busy / done        S1..S5 / S6
//   ovf_flag           sticky overflow, cleared by the next accepted start
//   instr_cnt          (only with INSTR_CNT_EN defined) count of writebacks, wraps at 256
//
// Build option: define INSTR_CNT_EN to add the instr_cnt output and its counter.

module instr_seq_ctrl #(
  parameter int AW  = 4,
  parameter int OPW = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [OPW+3*AW-1:0]   instr,
  input  logic                  overflow,
  output logic [2:0]            pst,
  output logic [AW-1:0]         Rd1,
  output logic [AW-1:0]         Rd2,
  output logic [AW-1:0]         Wr,
  output logic [OPW-1:0]        alu_op,
  output logic                  Reg_Write,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf_flag
`ifdef INSTR_CNT_EN
  ,
  output logic [7:0]            instr_cnt
`endif
);

  localparam int IW = OPW + 3*AW;

  localparam logic [2:0] S0 = 3'b000;  // idle
  localparam logic [2:0] S1 = 3'b001;  // decode
  localparam logic [2:0] S2 = 3'b010;  // read Rd1
  localparam logic [2:0] S3 = 3'b011;  // read Rd2
  localparam logic [2:0] S4 = 3'b100;  // latch Wr
  localparam logic [2:0] S5 = 3'b101;  // writeback
  localparam logic [2:0] S6 = 3'b110;  // done

  logic [2:0]    pst_q, pst_d;
  logic          start_q;
  logic [IW-1:0] instr_q, instr_d;
  logic          ovf_q, ovf_d;

  logic          start_edge;
  logic          accept;
  logic          active;
  logic [OPW-1:0] op;
  logic          op_writes;
  logic          reg_write;

  assign start_edge = start & ~start_q;
  assign accept     = (pst_q == S0) & start_edge;

  // Fields are only presented while an instruction is in flight; idle reads as zero.
  assign active = (pst_q >= S1) & (pst_q <= S6);
  assign op     = instr_q[IW-1 -: OPW];

  // Opcodes outside 1..8 (NOP and the undefined codes) walk the states without writing.
  assign op_writes = (op >= OPW'(1)) & (op <= OPW'(8));
  assign reg_write = (pst_q == S5) & op_writes;

  always_comb begin
    pst_d = pst_q;
    case (pst_q)
      S0:      if (start_edge) pst_d = S1;
      S1:      pst_d = S2;
      S2:      pst_d = S3;
      S3:      pst_d = S4;
      S4:      pst_d = S5;
      S5:      pst_d = S6;
      S6:      pst_d = S0;
      default: pst_d = S0;  // 111 recovers to idle
    endcase
  end

  always_comb begin
    instr_d = instr_q;
    if (accept) instr_d = instr;
  end

  // Set wins over clear; in practice they cannot coincide since clear happens only in S0.
  always_comb begin
    ovf_d = ovf_q;
    if (accept) ovf_d = 1'b0;
    if (reg_write && overflow) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pst_q   <= S0;
      start_q <= 1'b0;
      instr_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      pst_q   <= pst_d;
      start_q <= start;
      instr_q <= instr_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef INSTR_CNT_EN
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (reg_write) cnt_d = cnt_q + 8'd1;  // natural 8-bit wrap
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end

  assign instr_cnt = cnt_q;
`endif

  assign pst       = pst_q;
  assign Rd1       = active ? instr_q[3*AW-1 -: AW] : '0;
  assign Rd2       = active ? instr_q[2*AW-1 -: AW] : '0;
  assign Wr        = active ? instr_q[AW-1:0]       : '0;
  assign alu_op    = active ? op                    : '0;
  assign Reg_Write = reg_write;
  assign busy      = (pst_q >= S1) & (pst_q <= S5);
  assign done      = (pst_q == S6);
  assign ovf_flag  = ovf_q;

endmodule

// File: tb/tb_instr_seq_ctrl.sv
module tb_instr_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] instr;
  logic        overflow;
  logic [2:0]  pst;
  logic [3:0]  Rd1, Rd2, Wr, alu_op;
  logic        Reg_Write, busy, done, ovf_flag;
`ifdef INSTR_CNT_EN
  logic [7:0]  instr_cnt;
`endif

  instr_seq_ctrl #(.AW(4), .OPW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .instr     (instr),
    .overflow  (overflow),
    .pst       (pst),
    .Rd1       (Rd1),
    .Rd2       (Rd2),
    .Wr        (Wr),
    .alu_op    (alu_op),
    .Reg_Write (Reg_Write),
    .busy      (busy),
    .done      (done),
    .ovf_flag  (ovf_flag)
`ifdef INSTR_CNT_EN
    ,
    .instr_cnt (instr_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;
  int n_writes = 0;

  // Reference model: how many cycles into the current instruction we are (0 = idle).
  int          m_step;
  logic        m_prev_start;
  logic [15:0] m_instr;
  logic        m_ovf;
  int          m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit writes_op(input logic [15:0] w);
    int op;
    op = int'(w[15:12]);
    return (op >= 1) && (op <= 8);
  endfunction

  task automatic model_reset();
    m_step = 0; m_prev_start = 1'b0; m_instr = '0; m_ovf = 1'b0; m_cnt = 0;
  endtask

  task automatic compare_all();
    bit act, wr_exp;
    act    = (m_step != 0);
    wr_exp = (m_step == 5) && writes_op(m_instr);
    check("pst",       pst,       m_step);
    check("rd1",       Rd1,       act ? m_instr[11:8]  : 4'h0);
    check("rd2",       Rd2,       act ? m_instr[7:4]   : 4'h0);
    check("wr",        Wr,        act ? m_instr[3:0]   : 4'h0);
    check("alu_op",    alu_op,    act ? m_instr[15:12] : 4'h0);
    check("reg_write", Reg_Write, wr_exp);
    check("busy",      busy,      (m_step >= 1) && (m_step <= 5));
    check("done",      done,      m_step == 6);
    check("ovf_flag",  ovf_flag,  m_ovf);
`ifdef INSTR_CNT_EN
    check("instr_cnt", instr_cnt, m_cnt % 256);
`endif
  endtask

  // One clock: apply inputs, advance the model at the edge, compare on the falling edge.
  task automatic step(input logic s, input logic [15:0] w, input logic ov);
    bit edge_seen, wr_now;
    start = s; instr = w; overflow = ov;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      edge_seen    = s && !m_prev_start;
      m_prev_start = s;
      wr_now       = (m_step == 5) && writes_op(m_instr);
      if (m_step == 0) begin
        if (edge_seen) begin
          m_instr = w; m_step = 1; m_ovf = 1'b0;
        end
      end else begin
        if (wr_now && ov) m_ovf = 1'b1;
        if (wr_now) m_cnt++;
        m_step = (m_step + 1) % 7;
      end
    end
    @(negedge clk);
    compare_all();
    if (done === 1'b1) n_done++;
    if (Reg_Write === 1'b1) n_writes++;
  endtask

  task automatic run(input logic [15:0] w, input logic ov);
    step(1'b1, w, ov);
    repeat (7) step(1'b0, w, ov);
  endtask

  int exp_seq [7] = '{1, 2, 3, 4, 5, 6, 0};
  int d0, w0;

  initial begin
    rst_n = 1'b0; start = 1'b0; instr = '0; overflow = 1'b0;
    model_reset();
    #3;
    check("rst_pst",  pst, 3'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_rw",   Reg_Write, 1'b0);
    check("rst_ovf",  ovf_flag, 1'b0);
    check("rst_rd1",  Rd1, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) step(1'b0, 16'h0, 1'b0);

    // ADD 16'h1235: exact state walk and fields at writeback
    for (int i = 0; i < 7; i++) begin
      step(i == 0, 16'h1235, 1'b0);
      check("t2_pst", pst, exp_seq[i]);
      check("t2_done", done, i == 5);
      if (i == 4) begin
        check("t2_rw",  Reg_Write, 1'b1);
        check("t2_rd1", Rd1, 4'd2);
        check("t2_rd2", Rd2, 4'd3);
        check("t2_wr",  Wr, 4'd5);
        check("t2_op",  alu_op, 4'd1);
      end
    end
    step(1'b0, 16'h0, 1'b0);

    // NOP and undefined opcode: walk completes, no write
    d0 = n_done; w0 = n_writes;
    run(16'h0235, 1'b1);
    run(16'hA235, 1'b1);
    check("t3_writes", n_writes - w0, 0);
    check("t3_done",   n_done - d0, 2);
    check("t3_ovf",    ovf_flag, 1'b0);

    // Held start: one run only, re-press gives a second
    d0 = n_done;
    repeat (20) step(1'b1, 16'h2467, 1'b0);
    check("t4_held", n_done - d0, 1);
    step(1'b0, 16'h2467, 1'b0);
    repeat (8) step(1'b1, 16'h2467, 1'b0);
    check("t4_repress", n_done - d0, 2);
    step(1'b0, 16'h0, 1'b0);

    // Overflow stickiness
    run(16'h1111, 1'b1);
    repeat (3) step(1'b0, 16'h0, 1'b0);
    check("t5_set_held", ovf_flag, 1'b1);
    run(16'h0111, 1'b1);
    check("t5_cleared", ovf_flag, 1'b0);
    run(16'h1111, 1'b1);
    run(16'h3111, 1'b1);
    check("t5_reoverflow", ovf_flag, 1'b1);

    // Async reset mid-S3
    step(1'b1, 16'h5678, 1'b0);
    step(1'b0, 16'h5678, 1'b0);
    step(1'b0, 16'h5678, 1'b0);
    check("t1_in_s3", pst, 3'd3);
    #2 rst_n = 1'b0;
    #1;
    check("t1_pst",  pst, 3'd0);
    check("t1_rw",   Reg_Write, 1'b0);
    check("t1_busy", busy, 1'b0);
    model_reset();
    step(1'b0, 16'h0, 1'b0);
    rst_n = 1'b1;
    w0 = n_writes;
    repeat (10) step(1'b0, 16'h5678, 1'b1);
    check("t1_idle_pst", pst, 3'd0);
    check("t1_no_write", n_writes - w0, 0);

    // Randomized traffic against the model
    begin
      logic s;
      logic [15:0] w;
      s = 1'b0;
      for (int c = 0; c < 600; c++) begin
        if ($urandom_range(0, 3) == 0) s = ~s;
        w = 16'($urandom);
        if ($urandom_range(0, 1) == 0) w[15:12] = 4'($urandom_range(1, 8));
        step(s, w, 1'($urandom_range(0, 1)));
      end
      repeat (8) step(1'b0, 16'h0, 1'b0);
    end

`ifdef INSTR_CNT_EN
    // Counter wrap: 256 ADDs plus 3 NOPs, then one more ADD
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    step(1'b0, 16'h0, 1'b0);
    rst_n = 1'b1;
    for (int r = 0; r < 259; r++)
      run((r == 50 || r == 120 || r == 200) ? 16'h0235 : 16'h1235, 1'b0);
    check("t6_wrap", instr_cnt, 8'd0);
    run(16'h1235, 1'b0);
    check("t6_one", instr_cnt, 8'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
